uart_link: RTL and testbench

- Full-duplex UART block with a transmitter and a receiver sharing one clock and one synchronous reset.
- Frame format: 8N1-style, i.e. start bit low, p_WORD_LEN data bits LSB first, one stop bit high, no parity.
- Bit period is a fixed integer number of clock cycles.
- Sits between a byte-level producer/consumer and the serial pins; o_tx can loop back into i_rx for self-test.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_engine.sv | 135 +++++++++++++
 rtl/uart_tx_engine.sv | 109 ++++++++++
 rtl/uart_link.sv | 46 ++++
 tb/tb_uart_link.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit and receive engines.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_STOP  = 1'b1;
    localparam logic LINE_START = 1'b0;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizes the line, validates the start bit at mid-bit, samples data and stop.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int p_CLK_DIV  = 10,
    parameter int p_WORD_LEN = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  rx,
    output logic [p_WORD_LEN-1:0] rx_data,
    output logic                  rx_ready,
    output logic                  rx_err
);

    localparam int CW = $clog2(p_CLK_DIV);
    localparam int IW = $clog2(p_WORD_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(p_CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(p_CLK_DIV / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(p_WORD_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    rx_state_t             state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [p_WORD_LEN-1:0] shift_reg, shift_next;
    logic [p_WORD_LEN-1:0] data_reg, data_next;
    logic                  ready_reg, ready_next;
    logic                  err_reg, err_next;

    // The raw pin is asynchronous; nothing below looks at it before the last stage.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= {SYNC_STAGES{LINE_IDLE}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            ready_reg <= ready_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        ready_next = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (rx_s == LINE_START) begin
                    cnt_next   = '0;
                    state_next = RX_START;
                end
            end
            // Re-checking at half a bit both rejects short glitches and centres later samples.
            RX_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (rx_s == LINE_START) begin
                        idx_next   = '0;
                        state_next = RX_DATA;
                    end else begin
                        state_next = RX_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[p_WORD_LEN-1:1]};
                    if (idx_reg == IDX_LAST) begin
                        idx_next   = '0;
                        state_next = RX_STOP;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_s == LINE_STOP) begin
                        data_next  = shift_reg;
                        ready_next = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = RX_WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s == LINE_IDLE) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_data  = data_reg;
    assign rx_ready = ready_reg;
    assign rx_err   = err_reg;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, LSB-first data, one stop bit, fixed bit period.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int p_CLK_DIV  = 10,
    parameter int p_WORD_LEN = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  tx_dv,
    input  logic [p_WORD_LEN-1:0] tx_data,
    output logic                  tx,
    output logic                  tx_done,
    output logic                  tx_active
);

    localparam int CW = $clog2(p_CLK_DIV);
    localparam int IW = $clog2(p_WORD_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(p_CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(p_WORD_LEN - 1);

    tx_state_t             state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [p_WORD_LEN-1:0] shift_reg, shift_next;
    logic                  tx_reg, tx_next;
    logic                  done_reg, done_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= TX_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= LINE_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            done_reg  <= done_next;
        end
    end

    // The line level is computed one cycle ahead so o_tx comes straight from a flop.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        done_next  = 1'b0;
        case (state_reg)
            TX_IDLE: begin
                tx_next = LINE_IDLE;
                if (tx_dv) begin
                    shift_next = tx_data;
                    cnt_next   = '0;
                    idx_next   = '0;
                    tx_next    = LINE_START;
                    state_next = TX_START;
                end
            end
            TX_START: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    tx_next    = shift_reg[0];
                    state_next = TX_DATA;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            TX_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {1'b0, shift_reg[p_WORD_LEN-1:1]};
                    if (idx_reg == IDX_LAST) begin
                        idx_next   = '0;
                        tx_next    = LINE_STOP;
                        state_next = TX_STOP;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                        tx_next  = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            TX_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    tx_next    = LINE_IDLE;
                    state_next = TX_IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    assign tx        = tx_reg;
    assign tx_done   = done_reg;
    assign tx_active = (state_reg != TX_IDLE);

endmodule

// File: rtl/uart_link.sv
// Full-duplex UART: independent transmit and receive engines on a common clock and reset.
module uart_link
    import uart_pkg::*;
#(
    parameter int p_CLK_DIV  = 10,
    parameter int p_WORD_LEN = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tx_dv,
    input  logic [p_WORD_LEN-1:0] i_tx_data,
    output logic                  o_tx,
    output logic                  o_tx_done,
    output logic                  o_tx_active,
    input  logic                  i_rx,
    output logic [p_WORD_LEN-1:0] o_rx_data,
    output logic                  o_rx_ready,
    output logic                  o_rx_err
);

    uart_tx_engine #(
        .p_CLK_DIV (p_CLK_DIV),
        .p_WORD_LEN(p_WORD_LEN)
    ) u_tx (
        .clk      (i_clk),
        .srst     (i_rst),
        .tx_dv    (i_tx_dv),
        .tx_data  (i_tx_data),
        .tx       (o_tx),
        .tx_done  (o_tx_done),
        .tx_active(o_tx_active)
    );

    uart_rx_engine #(
        .p_CLK_DIV (p_CLK_DIV),
        .p_WORD_LEN(p_WORD_LEN)
    ) u_rx (
        .clk     (i_clk),
        .srst    (i_rst),
        .rx      (i_rx),
        .rx_data (o_rx_data),
        .rx_ready(o_rx_ready),
        .rx_err  (o_rx_err)
    );

endmodule

// File: tb/tb_uart_link.sv
// Bench for uart_link: loopback frames, back-to-back requests, glitches, framing errors, mid-frame reset.
module tb_uart_link;

    localparam int CLK_DIV  = 10;
    localparam int WORD_LEN = 8;
    localparam int FRAME    = (WORD_LEN + 2) * CLK_DIV;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_tx_dv;
    logic [7:0] i_tx_data;
    logic       o_tx;
    logic       o_tx_done;
    logic       o_tx_active;
    logic       i_rx;
    logic [7:0] o_rx_data;
    logic       o_rx_ready;
    logic       o_rx_err;

    logic rx_drv;
    logic loop_en;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] last_good = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_ready;
        int         exp_err;
    } rx_vec_t;

    rx_vec_t vecs[5];

    uart_link #(
        .p_CLK_DIV (CLK_DIV),
        .p_WORD_LEN(WORD_LEN)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_tx_dv    (i_tx_dv),
        .i_tx_data  (i_tx_data),
        .o_tx       (o_tx),
        .o_tx_done  (o_tx_done),
        .o_tx_active(o_tx_active),
        .i_rx       (i_rx),
        .o_rx_data  (o_rx_data),
        .o_rx_ready (o_rx_ready),
        .o_rx_err   (o_rx_err)
    );

    always #5 i_clk = ~i_clk;

    assign i_rx = loop_en ? o_tx : rx_drv;

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b == WORD_LEN + 1) return 1'b1;
        return d[b-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and run the output monitor / scoreboard.
    task automatic step();
        logic [7:0] exp;
        @(posedge i_clk);
        #1;
        if (o_rx_ready) begin
            ready_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got ready with data %0h, expected no word", o_rx_data);
            end else begin
                exp = sb.pop_front();
                last_good = exp;
                check("rx_data", 32'(o_rx_data), 32'(exp));
                $display("rx word %02h (expected %02h)", o_rx_data, exp);
            end
        end
        if (o_rx_err) err_cnt++;
        if (o_tx_done) done_cnt++;
    endtask

    // Send one frame and check it cycle by cycle; with hold, a different request stays asserted.
    task automatic tx_frame(input logic [7:0] d, input bit hold, input logic [7:0] hd);
        int r0;
        int d0;
        logic lvl;
        r0 = ready_cnt;
        d0 = done_cnt;
        i_tx_dv   = 1'b1;
        i_tx_data = d;
        if (loop_en) sb.push_back(d);
        step();
        if (hold) i_tx_data = hd;
        else i_tx_dv = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            lvl = frame_bit(d, k / CLK_DIV);
            check("tx_line", 32'({o_tx, o_tx_active, o_tx_done}), 32'({lvl, 1'b1, 1'b0}));
            if (hold && k == FRAME - 2) i_tx_dv = 1'b0;
            step();
        end
        check("tx_done_cycle", 32'({o_tx, o_tx_active, o_tx_done}), 32'(3'b101));
        check("tx_done_count", 32'(done_cnt - d0), 32'd1);
        if (loop_en) check("rx_before_done", 32'(ready_cnt - r0), 32'd1);
        $display("tx frame %02h sent", d);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
        for (int b = 0; b < WORD_LEN + 2; b++) begin
            rx_drv = (b == WORD_LEN + 1) ? stop_bit : frame_bit(d, b);
            repeat (CLK_DIV) step();
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int r0;
        int e0;
        int d0;

        vecs[0] = '{data: 8'h55, stop_bit: 1'b0, exp_ready: 0, exp_err: 1};
        vecs[1] = '{data: 8'hA5, stop_bit: 1'b1, exp_ready: 1, exp_err: 0};
        vecs[2] = '{data: 8'h3C, stop_bit: 1'b1, exp_ready: 1, exp_err: 0};
        vecs[3] = '{data: 8'h81, stop_bit: 1'b0, exp_ready: 0, exp_err: 1};
        vecs[4] = '{data: 8'h7E, stop_bit: 1'b1, exp_ready: 1, exp_err: 0};

        i_rst     = 1'b1;
        i_tx_dv   = 1'b0;
        i_tx_data = 8'h00;
        rx_drv    = 1'b1;
        loop_en   = 1'b0;

        repeat (3) step();
        check("reset_state", 32'({o_tx, o_tx_done, o_tx_active, o_rx_ready, o_rx_err, o_rx_data}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        i_rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle_state", 32'({o_tx, o_tx_done, o_tx_active, o_rx_ready, o_rx_err, o_rx_data}),
                  32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        end

        // Single loopback frame
        loop_en = 1'b1;
        d0 = done_cnt;
        tx_frame(8'hEE, 1'b0, 8'h00);
        repeat (20) step();
        check("ee_single_done", 32'(done_cnt - d0), 32'd1);
        check("ee_active_low", 32'(o_tx_active), 32'd0);

        // Back-to-back: the held request must be ignored, the re-assert in the done cycle accepted
        tx_frame(8'h00, 1'b1, 8'hFF);
        tx_frame(8'hFF, 1'b0, 8'h00);
        repeat (20) step();
        check("b2b_rx_data", 32'(o_rx_data), 32'h0FF);

        // Short low glitch on the line
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (5) step();
        r0 = ready_cnt;
        e0 = err_cnt;
        rx_drv = 1'b0;
        repeat (3) step();
        rx_drv = 1'b1;
        repeat (40) step();
        check("glitch_no_ready", 32'(ready_cnt - r0), 32'd0);
        check("glitch_no_err", 32'(err_cnt - e0), 32'd0);

        // Table of hand-driven RX frames
        for (int v = 0; v < 5; v++) begin
            r0 = ready_cnt;
            e0 = err_cnt;
            if (vecs[v].exp_ready != 0) sb.push_back(vecs[v].data);
            drive_frame(vecs[v].data, vecs[v].stop_bit);
            repeat (20) step();
            check("rx_vec_ready", 32'(ready_cnt - r0), 32'(vecs[v].exp_ready));
            check("rx_vec_err", 32'(err_cnt - e0), 32'(vecs[v].exp_err));
            check("rx_vec_data", 32'(o_rx_data), 32'(last_good));
            $display("rx vector %0d: data %02h stop %0b ready %0d err %0d", v, vecs[v].data,
                     vecs[v].stop_bit, ready_cnt - r0, err_cnt - e0);
        end

        // Reset during data bit 3 of a transmit frame
        d0 = done_cnt;
        i_tx_dv   = 1'b1;
        i_tx_data = 8'h96;
        step();
        i_tx_dv = 1'b0;
        repeat (43) step();
        check("tx_mid_bit3", 32'({o_tx, o_tx_active}), 32'({frame_bit(8'h96, 4), 1'b1}));
        i_rst = 1'b1;
        step();
        check("tx_reset_line", 32'({o_tx, o_tx_active, o_tx_done}), 32'(3'b100));
        i_rst = 1'b0;
        last_good = 8'h00;
        for (int i = 0; i < 120; i++) begin
            step();
            check("tx_after_reset", 32'({o_tx, o_tx_active}), 32'(2'b10));
        end
        check("tx_reset_no_done", 32'(done_cnt - d0), 32'd0);
        check("rx_data_reset", 32'(o_rx_data), 32'h0);

        loop_en = 1'b1;
        tx_frame(8'h3A, 1'b0, 8'h00);
        repeat (20) step();
        check("final_rx_data", 32'(o_rx_data), 32'h03A);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
